// File: rtl/dm_pkg.sv
// Shared definitions for the wait-stated data memory: access-type codes
// and the controller state encoding.
package dm_pkg;

  // Access types presented on dm_type.
  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAITS  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/dm_align.sv
// Byte-lane steering for the data memory: store-side byte enables and
// replicated write data, load-side lane extraction with sign/zero extension,
// and the misaligned/illegal access flag. Purely combinational.
module dm_align
  import dm_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  dm_type_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign rhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  // Decode access type into enables, steered write data, load result and error.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = 32'd0;
    err_o   = 1'b0;
    unique case (dm_type_i)
      DM_WORD: begin
        err_o   = (addr_lo_i != 2'b00);
        be_o    = 4'b1111;
        rdata_o = rword_i;
      end
      DM_HALF, DM_HALF_U: begin
        err_o   = addr_lo_i[0];
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = (dm_type_i == DM_HALF) ? {{16{rhalf[15]}}, rhalf} : {16'd0, rhalf};
      end
      DM_BYTE, DM_BYTE_U: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (dm_type_i == DM_BYTE) ? {{24{rbyte[7]}}, rbyte} : {24'd0, rbyte};
      end
      default: err_o = 1'b1;
    endcase
    // A failed access neither writes nor returns data.
    if (err_o) begin
      be_o    = 4'b0000;
      rdata_o = 32'd0;
    end
  end

endmodule

// File: rtl/dm_ws.sv
// Wait-stated data memory with req/ack handshake. A request is latched in
// IDLE, WAIT stall cycles follow, the array is accessed once, and a single
// RESP cycle pulses ack with err. Reset aborts any access in flight.
module dm_ws
  import dm_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        dm_type,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int         DEPTH   = 2 ** (ADDR_W - 2);
  localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                latch_en;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          type_q;
  logic [31:0]         din_q;
  logic [31:0]         dout_q;
  logic                err_q;
  logic [31:0]         mem_q [DEPTH];

  logic [ADDR_W-3:0]   word_idx;
  logic [31:0]         rword;
  logic [3:0]          be;
  logic [31:0]         wdata_sh;
  logic [31:0]         rdata;
  logic                align_err;
  logic                do_access;

  assign word_idx  = addr_q[ADDR_W-1:2];
  assign rword     = mem_q[word_idx];
  assign do_access = (state_q == ST_ACCESS);

  dm_align u_align (
    .addr_lo_i (addr_q[1:0]),
    .dm_type_i (type_q),
    .wdata_i   (din_q),
    .rword_i   (rword),
    .be_o      (be),
    .wdata_o   (wdata_sh),
    .rdata_o   (rdata),
    .err_o     (align_err)
  );

  // Next-state and wait-counter logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          latch_en = 1'b1;
          if (WAIT > 0) begin
            state_d = ST_WAITS;
            cnt_d   = WAIT_M1;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAITS: begin
        if (cnt_q == 4'd0) state_d = ST_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Control state, counter and response registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      dout_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (do_access) begin
        dout_q <= rdata;
        err_q  <= align_err;
      end
    end
  end

  // Request latch; contents only matter after a request is accepted.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      we_q   <= we;
      addr_q <= addr;
      type_q <= dm_type;
      din_q  <= din;
    end
  end

  // Byte-lane writes into the word array, suppressed when reset coincides.
  // NOTE: the array has no reset so it maps onto RAM; reset instead gates the
  // write enable so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (do_access && we_q && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
      end
    end
  end

  assign dout = dout_q;
  assign err  = err_q;
  assign ack  = (state_q == ST_RESP);
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dm_ws.sv
// Directed bench for dm_ws: a WAIT=2 instance for access semantics, errors
// and reset abort, and a WAIT=0 instance for back-to-back throughput.
module tb_dm_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_req, a_we, a_ack, a_err, a_busy;
  logic [8:0]  a_addr;
  logic [2:0]  a_type;
  logic [31:0] a_din, a_dout;
  logic        b_reset, b_req, b_we, b_ack, b_err, b_busy;
  logic [8:0]  b_addr;
  logic [2:0]  b_type;
  logic [31:0] b_din, b_dout;

  int checks = 0;
  int errors = 0;

  dm_ws #(.ADDR_W(9), .WAIT(2)) u_dut_a (
    .clk(clk), .reset(a_reset), .req(a_req), .we(a_we), .addr(a_addr),
    .dm_type(a_type), .din(a_din), .dout(a_dout), .ack(a_ack), .err(a_err),
    .busy(a_busy)
  );

  dm_ws #(.ADDR_W(9), .WAIT(0)) u_dut_b (
    .clk(clk), .reset(b_reset), .req(b_req), .we(b_we), .addr(b_addr),
    .dm_type(b_type), .din(b_din), .dout(b_dout), .ack(b_ack), .err(b_err),
    .busy(b_busy)
  );

  // One complete transaction on instance A (sel=0) or B (sel=1). lat is the
  // number of cycles from the accepting IDLE cycle to ack, -1 on timeout.
  task automatic access(input bit sel, input logic w, input logic [8:0] ad,
                        input logic [2:0] t, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
    int guard;
    lat = -1; rd = 'x; e = 1'bx; guard = 0;
    @(negedge clk);
    while ((sel ? b_busy : a_busy) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sel) begin b_req = 1; b_we = w; b_addr = ad; b_type = t; b_din = d; end
    else     begin a_req = 1; a_we = w; a_addr = ad; a_type = t; a_din = d; end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sel ? b_ack : a_ack) begin
        lat = k;
        rd  = sel ? b_dout : a_dout;
        e   = sel ? b_err : a_err;
        break;
      end
    end
    if (sel) b_req = 0; else a_req = 0;
  endtask

  task automatic test_reset;
    a_reset = 1; b_reset = 1;
    a_req = 0; a_we = 0; a_addr = '0; a_type = '0; a_din = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_type = '0; b_din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_dout, a_ack, a_err, a_busy} !== 35'd0) begin
      errors++;
      $display("FAIL reset_a got dout=%h ack=%b err=%b busy=%b want all 0", a_dout, a_ack, a_err, a_busy);
    end
    checks++;
    if ({b_dout, b_ack, b_err, b_busy} !== 35'd0) begin
      errors++;
      $display("FAIL reset_b got dout=%h ack=%b err=%b busy=%b want all 0", b_dout, b_ack, b_err, b_busy);
    end
    a_reset = 0; b_reset = 0;
  endtask

  task automatic test_word;
    logic [31:0] rd; logic e; int lat;
    access(0, 1, 9'h010, 3'b000, 32'h12345678, rd, e, lat);
    checks++;
    if (lat !== 4 || e !== 1'b0) begin
      errors++;
      $display("FAIL sw_010 got lat=%0d err=%b want lat=4 err=0", lat, e);
    end
    access(0, 0, 9'h010, 3'b000, 32'h0, rd, e, lat);
    checks++;
    if (lat !== 4 || e !== 1'b0 || rd !== 32'h12345678) begin
      errors++;
      $display("FAIL lw_010 got lat=%0d err=%b dout=%h want 4 0 12345678", lat, e, rd);
    end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic e; int lat;
    logic [2:0]  ty  [3] = '{3'b000, 3'b011, 3'b100};
    logic [8:0]  ad  [3] = '{9'h010, 9'h011, 9'h011};
    logic [31:0] exp [3] = '{32'h1234AB78, 32'hFFFFFFAB, 32'h000000AB};
    access(0, 1, 9'h011, 3'b011, 32'h000000AB, rd, e, lat);
    checks++;
    if (lat !== 4 || e !== 1'b0) begin
      errors++;
      $display("FAIL sb_011 got lat=%0d err=%b want lat=4 err=0", lat, e);
    end
    for (int i = 0; i < 3; i++) begin
      access(0, 0, ad[i], ty[i], 32'h0, rd, e, lat);
      checks++;
      if (lat !== 4 || e !== 1'b0 || rd !== exp[i]) begin
        errors++;
        $display("FAIL byte_load%0d got lat=%0d err=%b dout=%h want 4 0 %h", i, lat, e, rd, exp[i]);
      end
    end
  endtask

  task automatic test_half;
    logic [31:0] rd; logic e; int lat;
    logic [2:0]  ty  [4] = '{3'b001, 3'b010, 3'b000, 3'b010};
    logic [8:0]  ad  [4] = '{9'h022, 9'h022, 9'h020, 9'h020};
    logic [31:0] exp [4] = '{32'hFFFF8001, 32'h00008001, 32'h80013344, 32'h00003344};
    access(0, 1, 9'h020, 3'b000, 32'h11223344, rd, e, lat);
    access(0, 1, 9'h022, 3'b001, 32'h00008001, rd, e, lat);
    checks++;
    if (lat !== 4 || e !== 1'b0) begin
      errors++;
      $display("FAIL sh_022 got lat=%0d err=%b want lat=4 err=0", lat, e);
    end
    for (int i = 0; i < 4; i++) begin
      access(0, 0, ad[i], ty[i], 32'h0, rd, e, lat);
      checks++;
      if (lat !== 4 || e !== 1'b0 || rd !== exp[i]) begin
        errors++;
        $display("FAIL half_load%0d got lat=%0d err=%b dout=%h want 4 0 %h", i, lat, e, rd, exp[i]);
      end
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic e; int lat;
    logic        w   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [8:0]  ad  [4] = '{9'h013, 9'h021, 9'h010, 9'h010};
    logic [2:0]  ty  [4] = '{3'b000, 3'b001, 3'b111, 3'b101};
    logic [31:0] d   [4] = '{32'hDEADBEEF, 32'h0000FFFF, 32'hFFFFFFFF, 32'h0};
    logic [8:0]  rad [2] = '{9'h010, 9'h020};
    logic [31:0] exp [2] = '{32'h1234AB78, 32'h80013344};
    for (int i = 0; i < 4; i++) begin
      // A good load first so a zeroed dout is a real change.
      access(0, 0, 9'h010, 3'b000, 32'h0, rd, e, lat);
      access(0, w[i], ad[i], ty[i], d[i], rd, e, lat);
      checks++;
      if (lat !== 4 || e !== 1'b1 || rd !== 32'h0) begin
        errors++;
        $display("FAIL err_case%0d got lat=%0d err=%b dout=%h want 4 1 00000000", i, lat, e, rd);
      end
    end
    for (int i = 0; i < 2; i++) begin
      access(0, 0, rad[i], 3'b000, 32'h0, rd, e, lat);
      checks++;
      if (e !== 1'b0 || rd !== exp[i]) begin
        errors++;
        $display("FAIL err_reload%0d got err=%b dout=%h want 0 %h", i, e, rd, exp[i]);
      end
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd; logic e; int lat; int stray;
    access(0, 1, 9'h030, 3'b000, 32'hCAFEF00D, rd, e, lat);
    access(0, 0, 9'h030, 3'b000, 32'h0, rd, e, lat);
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 9'h030; a_type = 3'b000; a_din = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_ack !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_access_cycle got ack=%b busy=%b want 0 1", a_ack, a_busy);
    end
    a_reset = 1; a_req = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_dout, a_ack, a_err, a_busy} !== 35'd0) begin
      errors++;
      $display("FAIL abort_outputs got dout=%h ack=%b err=%b busy=%b want all 0", a_dout, a_ack, a_err, a_busy);
    end
    a_reset = 0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_ack !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL abort_no_ack got %0d ack cycles want 0", stray);
    end
    access(0, 0, 9'h030, 3'b000, 32'h0, rd, e, lat);
    checks++;
    if (lat !== 4 || e !== 1'b0 || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL abort_reload got lat=%0d err=%b dout=%h want 4 0 cafef00d", lat, e, rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic e; int lat;
    access(1, 1, 9'h004, 3'b000, 32'h5A5AA5A5, rd, e, lat);
    checks++;
    if (lat !== 2 || e !== 1'b0) begin
      errors++;
      $display("FAIL b_sw_004 got lat=%0d err=%b want lat=2 err=0", lat, e);
    end
    @(negedge clk);
    b_req = 1; b_we = 0; b_addr = 9'h004; b_type = 3'b000; b_din = 32'h0;
    // Cycle c=0 is the accepting IDLE cycle; ack lands on c=2,5,8,11.
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (b_busy !== (c % 3 != 0) || b_ack !== (c % 3 == 2)) begin
        errors++;
        $display("FAIL b2b_cycle%0d got busy=%b ack=%b want %b %b", c, b_busy, b_ack, (c % 3 != 0), (c % 3 == 2));
      end
      if (c % 3 == 2) begin
        checks++;
        if (b_dout !== 32'h5A5AA5A5 || b_err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_data%0d got dout=%h err=%b want 5a5aa5a5 0", c, b_dout, b_err);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    b_req = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_errors;
    test_reset_abort;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_ws.md
# dm_ws

Parametrised, wait-stated data memory for the multi-cycle and pipelined CPU generations. It is the successor to the single-cycle data memory. It keeps the same DMType byte/half/word access semantics and adds three things: a configurable depth, a configurable number of wait states, and a req/ack handshake so the CPU can stall. It sits between the CPU's memory port and the computer top, in the same position as the single-cycle data memory.

## Interface
Parameters:
- ADDR_W, 9: byte-address width. Depth is 2**(ADDR_W-2) 32-bit words.
- WAIT, 2: wait-state cycles inserted before each access. Legal range 0..15.

Ports (clock and reset first):
- clk  in  1: CPU clock. Everything is rising-edge.
- reset  in  1: synchronous, active-high reset.
- req  in  1: access request. Sampled only in IDLE. The requester holds req, we, addr, dm_type and din stable until ack.
- we  in  1: 1 means store, 0 means load.
- addr  in  ADDR_W: byte address.
- dm_type  in  3: access type.
  - 000 word
  - 001 half
  - 010 half unsigned
  - 011 byte
  - 100 byte unsigned
  - 101..111 illegal
- din  in  32: store data, right-aligned.
- dout  out  32: load result. Registered; held until the next RESP.
- ack  out  1: one-cycle completion pulse.
- err  out  1: valid with ack. Misaligned or illegal access.
- busy  out  1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAITS, ACCESS, RESP.
- IDLE:
  - With req=1, latch we, addr, dm_type and din.
  - Go to WAITS if WAIT>0, otherwise go to ACCESS.
  - With req=0, stay in IDLE.
- WAITS:
  - A 4-bit counter loads WAIT-1 on entry and decrements each cycle.
  - Go to ACCESS when the counter is 0.
- ACCESS performs the operation, then goes to RESP.
- Stores (we=1) write only the addressed byte lanes of word addr[ADDR_W-1:2]:
  - Byte: lane addr[1:0] gets din[7:0].
  - Half: lanes {addr[1],1'b1} and {addr[1],1'b0} get din[15:0].
  - Word: all four lanes.
  - Lanes are little-endian: lane 0 is bits [7:0].
- Loads (we=0):
  - Extract the addressed lane(s).
  - Sign-extend for 001 and 011. Zero-extend for 010 and 100. Word is passed through.
  - The result is registered into dout.
- Error check, evaluated on the latched request in ACCESS:
  - Conditions: half with addr[0]=1, word with addr[1:0]!=0, or dm_type 101..111.
  - Effect: no memory write, dout is loaded with 0, err=1 in RESP.
- RESP: ack=1, err valid, then return unconditionally to IDLE.
  - A still-asserted req is re-sampled in the following IDLE cycle.
  - The requester must drop req on ack or issue a new request.
- Memory contents are not reset or initialised. Simulation may preload via $readmemh in the bench.
- Addresses wrap naturally within 2**ADDR_W bytes. There is no out-of-range case.

## Timing
- Reset values: state IDLE, counter 0, dout 0, ack 0, err 0, busy 0.
- Latency: request accepted in cycle n gives ack in cycle n+WAIT+2.
  - WAIT=0: IDLE, ACCESS, RESP, so ack at n+2.
- Throughput: one access per WAIT+3 cycles when back-to-back.
- busy rises in the cycle after acceptance and falls in the cycle after RESP.
- Reset has priority in every state:
  - Reset in WAITS or ACCESS aborts the access. The store is not performed, even if reset coincides with the ACCESS edge.
  - No ack is produced after reset.
- req is a don't-care while busy=1. Changing request fields while busy has no effect, because they were latched in IDLE.

## Structure
- Package dm_pkg holds:
  - the DMType localparams (DM_WORD, DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U);
  - the FSM state encoding (2 bits).
- Sub-module dm_align is combinational and handles byte-lane logic only:
  - store side: byte-enable mask and lane-shifted write data;
  - load side: lane extraction and sign/zero extension;
  - misalignment/illegal flag.
- The top holds the FSM, wait counter, request latch, word array and dout register.

## Test plan
- WAIT=2, store word 0x12345678 at addr 0x010, then load word from 0x010. Required:
  - ack 4 cycles after each acceptance;
  - dout=0x12345678, err=0.
- Store byte 0xAB at 0x011 over that word, then load word (0x1234AB78), lb 0x011 (0xFFFFFFAB) and lbu 0x011 (0x000000AB).
- Store half 0x8001 at 0x022, then lh 0x022 (0xFFFF8001) and lhu 0x022 (0x00008001). Bytes 0x020/0x021 are unchanged.
- Misaligned and illegal cases: sw at 0x013, sh at 0x021, and dm_type=3'b111. Required for each: ack with err=1, dout=0, target word unchanged on reload.
- Reset asserted in the ACCESS cycle of a sw 0xDEADBEEF to 0x030. Required:
  - no ack;
  - all outputs 0 the next cycle;
  - a reload of 0x030 returns the prior value.
- WAIT=0 instance with back-to-back requests (req held high):
  - ack every 3 cycles, at n+2, n+5, ...;
  - busy low for exactly one cycle between accesses.
